alarm_ctrl: RTL and testbench



---
 rtl/alarm_pkg.sv | 22 ++
 rtl/alarm_ctrl_if.sv | 34 +++
 rtl/alarm_slot.sv | 48 ++++
 rtl/alarm_ctrl.sv | 159 +++++++++++++++
 tb/tb_alarm_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm controller: FSM state encoding,
// the BCD zero constant and the default parameter values.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_e;

    localparam logic [7:0] BCD_ZERO = 8'h00;

    localparam int DEF_NUM_ALARMS  = 4;
    localparam int DEF_RING_SECS   = 60;
    localparam int DEF_SNOOZE_SECS = 300;
    localparam int DEF_MAX_SNOOZE  = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Bundle of time, programming, button and status signals for alarm_ctrl.
// The master side drives time/programming/buttons; the slave side is the controller.
interface alarm_ctrl_if;

    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_hour;
    logic [7:0] wr_min;
    logic       wr_enable;
    logic       stop_btn;
    logic       snooze_btn;
    logic       Sound;
    logic       ringing;
    logic [2:0] active_idx;
    logic [2:0] snooze_left;

    modport master (
        output hour, min, sec,
        output wr_en, wr_idx, wr_hour, wr_min, wr_enable,
        output stop_btn, snooze_btn,
        input  Sound, ringing, active_idx, snooze_left
    );

    modport slave (
        input  hour, min, sec,
        input  wr_en, wr_idx, wr_hour, wr_min, wr_enable,
        input  stop_btn, snooze_btn,
        output Sound, ringing, active_idx, snooze_left
    );

endinterface

// File: rtl/alarm_slot.sv
// One alarm channel: programmed hour/minute, arm bit, and a match detector
// that fires only on the first edge of a matching second-00.
module alarm_slot
    import alarm_pkg::*;
(
    input  logic       clk1hz,
    input  logic       rst_n,
    input  logic       wr_sel_i,
    input  logic       wr_enable_i,
    input  logic [7:0] wr_hour_i,
    input  logic [7:0] wr_min_i,
    input  logic [7:0] hour_i,
    input  logic [7:0] min_i,
    input  logic [7:0] sec_i,
    output logic       match_o
);

    logic [7:0] ahour_q;
    logic [7:0] amin_q;
    logic       armed_q;
    logic       fired_q;
    logic       hit_now;

    assign hit_now = armed_q && (hour_i == ahour_q) && (min_i == amin_q) && (sec_i == BCD_ZERO);

    // Suppress re-firing while the time inputs stay on the matching second.
    assign match_o = hit_now && !fired_q;

    // NOTE: the alarm time is held in plain flops rather than a RAM array,
    // so it can take the asynchronous reset along with the rest of the state.
    always_ff @(posedge clk1hz or negedge rst_n) begin
        if (!rst_n) begin
            ahour_q <= BCD_ZERO;
            amin_q  <= BCD_ZERO;
            armed_q <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values.
            if (wr_sel_i) begin
                ahour_q <= wr_hour_i;
                amin_q  <= wr_min_i;
                armed_q <= wr_enable_i;
            end
            fired_q <= hit_now;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Multi-channel alarm clock controller: lowest-index match starts a ring that
// auto-stops, can be stopped, or snoozed when built with ALARM_SNOOZE_EN.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS  = DEF_NUM_ALARMS,
    parameter int RING_SECS   = DEF_RING_SECS,
    parameter int SNOOZE_SECS = DEF_SNOOZE_SECS,
    parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
    input  logic        clk1hz,
    input  logic        rst_n,
    alarm_ctrl_if.slave bus
);

`ifdef ALARM_SNOOZE_EN
    localparam int CNT_MAX = max_int(RING_SECS, SNOOZE_SECS);
`else
    localparam int CNT_MAX = RING_SECS;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_SECS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [NUM_ALARMS-1:0] slot_hit;
    logic [NUM_ALARMS-1:0] wr_sel;
    logic                  any_hit;
    logic [2:0]            hit_idx;
    logic                  disarm_active;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             sound_q;

    // Out-of-range wr_idx selects no slot, so such writes fall away here.
    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
        assign wr_sel[g] = bus.wr_en && (bus.wr_idx == 3'(g));

        alarm_slot u_slot (
            .clk1hz      (clk1hz),
            .rst_n       (rst_n),
            .wr_sel_i    (wr_sel[g]),
            .wr_enable_i (bus.wr_enable),
            .wr_hour_i   (bus.wr_hour),
            .wr_min_i    (bus.wr_min),
            .hour_i      (bus.hour),
            .min_i       (bus.min),
            .sec_i       (bus.sec),
            .match_o     (slot_hit[g])
        );
    end

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through it can infer a latch.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                any_hit = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    assign disarm_active = bus.wr_en && !bus.wr_enable && (bus.wr_idx == idx_q);

`ifdef ALARM_SNOOZE_EN
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS);
    localparam logic [2:0]       SNOOZE_MAX  = 3'(MAX_SNOOZE);

    logic [2:0] left_q, left_d;

    always_ff @(posedge clk1hz or negedge rst_n) begin
        if (!rst_n) left_q <= 3'd0;
        else        left_q <= left_d;
    end

    assign bus.snooze_left = left_q;
`else
    logic unused_snooze;
    assign unused_snooze   = bus.snooze_btn ^ (MAX_SNOOZE > 0) ^ (SNOOZE_SECS > 0);
    assign bus.snooze_left = 3'd0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`ifdef ALARM_SNOOZE_EN
        left_d  = left_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_hit) begin
                    state_d = RINGING;
                    cnt_d   = RING_LOAD;
                    idx_d   = hit_idx;
`ifdef ALARM_SNOOZE_EN
                    left_d  = SNOOZE_MAX;
`endif
                end
            end
            RINGING: begin
                if (disarm_active || bus.stop_btn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef ALARM_SNOOZE_EN
                end else if (bus.snooze_btn && (left_q != 3'd0)) begin
                    state_d = SNOOZE;
                    cnt_d   = SNOOZE_LOAD;
                    left_d  = left_q - 3'd1;
`endif
                end else begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                    if (cnt_d == '0) state_d = IDLE;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (disarm_active || bus.stop_btn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                    if (cnt_d == '0) begin
                        state_d = RINGING;
                        cnt_d   = RING_LOAD;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk1hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            sound_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sound_q <= (state_d == RINGING);
        end
    end

    assign bus.Sound      = sound_q;
    assign bus.ringing    = (state_q == RINGING);
    assign bus.active_idx = idx_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: stimulus queues expected status per cycle,
// a negedge monitor pops and compares. Snooze checks follow ALARM_SNOOZE_EN.
module tb_alarm_ctrl;

`ifdef ALARM_SNOOZE_EN
    localparam logic [2:0] EXP_MAX = 3'd3;
`else
    localparam logic [2:0] EXP_MAX = 3'd0;
`endif

    typedef struct {
        int         at;
        string      name;
        bit         snd;
        bit         chk_idx;
        logic [2:0] idx;
        bit         chk_left;
        logic [2:0] left;
    } exp_t;

    logic clk1hz = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    exp_t sb[$];

    always #5 clk1hz = ~clk1hz;
    always @(posedge clk1hz) cyc <= cyc + 1;

    alarm_ctrl_if bus ();

    alarm_ctrl #(
        .NUM_ALARMS  (4),
        .RING_SECS   (60),
        .SNOOZE_SECS (300),
        .MAX_SNOOZE  (3)
    ) dut (
        .clk1hz (clk1hz),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    task automatic check(input exp_t e);
        bit ok;
        ok = (bus.Sound === e.snd) && (bus.ringing === e.snd)
             && (!e.chk_idx || (bus.active_idx === e.idx))
             && (!e.chk_left || (bus.snooze_left === e.left));
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s @cyc %0d: got Sound=%b ringing=%b active_idx=%0d snooze_left=%0d, want Sound=%b ringing=%b active_idx=%0d(chk %0d) snooze_left=%0d(chk %0d)",
                      e.name, cyc, bus.Sound, bus.ringing, bus.active_idx, bus.snooze_left,
                      e.snd, e.snd, e.idx, e.chk_idx, e.left, e.chk_left);
    endtask

    always @(negedge clk1hz) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check(sb[i]);
                sb.delete(i);
            end
        end
    end

    task automatic exp_snd(input int at, input string name, input bit snd);
        exp_t e;
        e = '{at: at, name: name, snd: snd, chk_idx: 1'b0, idx: 3'd0, chk_left: 1'b0, left: 3'd0};
        sb.push_back(e);
    endtask

    task automatic exp_full(input int at, input string name, input bit snd,
                            input logic [2:0] idx, input logic [2:0] left);
        exp_t e;
        e = '{at: at, name: name, snd: snd, chk_idx: 1'b1, idx: idx, chk_left: 1'b1, left: left};
        sb.push_back(e);
    endtask

    task automatic exp_left(input int at, input string name, input bit snd, input logic [2:0] left);
        exp_t e;
        e = '{at: at, name: name, snd: snd, chk_idx: 1'b0, idx: 3'd0, chk_left: 1'b1, left: left};
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk1hz);
    endtask

    task automatic wait_until(input int at);
        while (cyc < at) tick();
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.hour = h;
        bus.min  = m;
        bus.sec  = s;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [7:0] h, input logic [7:0] m, input logic en);
        bus.wr_en     = 1'b1;
        bus.wr_idx    = idx;
        bus.wr_hour   = h;
        bus.wr_min    = m;
        bus.wr_enable = en;
        tick();
        bus.wr_en     = 1'b0;
    endtask

    task automatic start(input logic [7:0] h, input logic [7:0] m, output int c);
        set_time(h, m, 8'h00);
        c = cyc;
    endtask

    task automatic fire_end();
        tick();
        bus.sec = 8'h01;
    endtask

    task automatic press(input logic stop, input logic snooze);
        bus.stop_btn   = stop;
        bus.snooze_btn = snooze;
        tick();
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
    endtask

    initial begin
        int c;
        rst_n          = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_idx     = 3'd0;
        bus.wr_hour    = 8'h00;
        bus.wr_min     = 8'h00;
        bus.wr_enable  = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
        set_time(8'h00, 8'h00, 8'h01);
        exp_full(1, "reset_state", 1'b0, 3'd0, 3'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // ch1 07:30, time held on the matching second for the whole ring
        wr(3'd1, 8'h07, 8'h30, 1'b1);
        start(8'h07, 8'h30, c);
        exp_full(c + 1, "t1_ring_start", 1'b1, 3'd1, EXP_MAX);
        exp_snd(c + 60, "t1_last_ring_cycle", 1'b1);
        exp_snd(c + 61, "t1_auto_stop", 1'b0);
        exp_snd(c + 62, "t1_no_refire", 1'b0);
        exp_snd(c + 64, "t1_no_refire_late", 1'b0);
        wait_until(c + 65);
        bus.sec = 8'h01;

        // ch0 and ch2 both 06:00; ch1 match mid-ring must be dropped
        wr(3'd0, 8'h06, 8'h00, 1'b1);
        wr(3'd2, 8'h06, 8'h00, 1'b1);
        start(8'h06, 8'h00, c);
        exp_full(c + 1, "t2_lowest_idx", 1'b1, 3'd0, EXP_MAX);
        exp_snd(c + 60, "t2_still_ringing", 1'b1);
        exp_snd(c + 61, "t2_end", 1'b0);
        exp_snd(c + 62, "t2_single_ring", 1'b0);
        exp_snd(c + 70, "t2_not_queued", 1'b0);
        fire_end();
        wait_until(c + 10);
        set_time(8'h07, 8'h30, 8'h00);
        fire_end();
        wait_until(c + 71);

        // stop and snooze on the same edge: stop wins
        start(8'h06, 8'h00, c);
        exp_snd(c + 3, "t3_before_stop", 1'b1);
        exp_left(c + 4, "t3_stop_priority", 1'b0, EXP_MAX);
        exp_snd(c + 5, "t3_stays_idle", 1'b0);
        fire_end();
        wait_until(c + 3);
        press(1'b1, 1'b1);
        wait_until(c + 6);

        // snooze sequence
        start(8'h06, 8'h00, c);
        exp_full(c + 1, "t4_ring", 1'b1, 3'd0, EXP_MAX);
`ifdef ALARM_SNOOZE_EN
        exp_left(c + 3, "t4_snooze1", 1'b0, 3'd2);
        exp_snd(c + 302, "t4_snooze1_end", 1'b0);
        exp_left(c + 303, "t4_rering1", 1'b1, 3'd2);
        exp_left(c + 306, "t4_snooze2", 1'b0, 3'd1);
        exp_left(c + 606, "t4_rering2", 1'b1, 3'd1);
        exp_left(c + 608, "t4_snooze3", 1'b0, 3'd0);
        exp_left(c + 908, "t4_rering3", 1'b1, 3'd0);
        exp_left(c + 910, "t4_fourth_ignored", 1'b1, 3'd0);
        exp_snd(c + 967, "t4_final_last", 1'b1);
        exp_snd(c + 968, "t4_final_end", 1'b0);
        fire_end();
        wait_until(c + 2);
        press(1'b0, 1'b1);
        wait_until(c + 305);
        press(1'b0, 1'b1);
        wait_until(c + 607);
        press(1'b0, 1'b1);
        wait_until(c + 909);
        press(1'b0, 1'b1);
        wait_until(c + 970);
`else
        exp_left(c + 3, "t4_snooze_ignored", 1'b1, 3'd0);
        exp_snd(c + 61, "t4_end", 1'b0);
        fire_end();
        wait_until(c + 2);
        press(1'b0, 1'b1);
        wait_until(c + 63);
`endif

        // ring on ch3: other-channel write keeps ringing, own disarm stops
        wr(3'd3, 8'h08, 8'h15, 1'b1);
        start(8'h08, 8'h15, c);
        exp_full(c + 1, "t5_ring_ch3", 1'b1, 3'd3, EXP_MAX);
        exp_full(c + 4, "t5_other_write", 1'b1, 3'd3, EXP_MAX);
        exp_snd(c + 5, "t5_before_disarm", 1'b1);
        exp_snd(c + 6, "t5_disarm_stops", 1'b0);
        fire_end();
        wait_until(c + 3);
        wr(3'd1, 8'h00, 8'h00, 1'b0);
        wait_until(c + 5);
        wr(3'd3, 8'h08, 8'h15, 1'b0);

        // out-of-range index must not alias onto ch3
        wr(3'd3, 8'h08, 8'h15, 1'b1);
        wr(3'd7, 8'h08, 8'h15, 1'b0);
        start(8'h08, 8'h15, c);
        exp_full(c + 1, "t5_oob_write_ignored", 1'b1, 3'd3, EXP_MAX);
        exp_snd(c + 3, "t5_stop", 1'b0);
        fire_end();
        wait_until(c + 2);
        press(1'b1, 1'b0);
        wait_until(c + 4);

        // asynchronous reset between edges while ringing
        start(8'h06, 8'h00, c);
        exp_full(c + 1, "t6_ring", 1'b1, 3'd0, EXP_MAX);
        exp_full(c + 3, "t6_async_reset", 1'b0, 3'd0, 3'd0);
        fire_end();
        wait_until(c + 2);
        @(posedge clk1hz);
        #2 rst_n = 1'b0;
        @(negedge clk1hz);
        #1 rst_n = 1'b1;
        start(8'h06, 8'h00, c);
        exp_full(c + 1, "t6_ch0_disarmed", 1'b0, 3'd0, 3'd0);
        exp_snd(c + 2, "t6_ch0_still_quiet", 1'b0);
        fire_end();
        tick();
        start(8'h08, 8'h15, c);
        exp_snd(c + 1, "t6_ch3_disarmed", 1'b0);
        fire_end();
        tick();

        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        foreach (sb[i]) begin
            n_total++;
            $display("FAIL %s: never checked, expected at cyc %0d, now cyc %0d", sb[i].name, sb[i].at, cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
